// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster timing defaults and shared widths for the VGA sync driver.
// Pure definitions, no logic, no latency.
// No flow control; consumers pick these up as parameter defaults.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int CNT_W     = 10;
  localparam int ADDRH_W   = 10;
  localparam int ADDRV_W   = 9;
  localparam int COLOUR_W  = 8;

  localparam logic [COLOUR_W-1:0] BLACK = 8'h00;

  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_sync_driver_if.sv
// Pixel-address / colour bundle between the sync driver and its producer and VGA pins.
// Wires only, no latency.
// No backpressure: the producer must follow the address within one pixel.
interface vga_sync_driver_if;
  import vga_timing_pkg::*;

  logic [COLOUR_W-1:0] COLOUR_IN;
  logic [ADDRH_W-1:0]  ADDRH;
  logic [ADDRV_W-1:0]  ADDRV;
  logic                PIX_EN;
  logic                REFRESH;
  logic [COLOUR_W-1:0] COLOUR_OUT;
  logic                HS;
  logic                VS;

  modport master (
    input  COLOUR_IN,
    output ADDRH, ADDRV, PIX_EN, REFRESH, COLOUR_OUT, HS, VS
  );

  modport slave (
    output COLOUR_IN,
    input  ADDRH, ADDRV, PIX_EN, REFRESH, COLOUR_OUT, HS, VS
  );

endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 raster axis counter; wrap flags the terminal count.
// Count updates on the CLK where en is high; wrap is combinational.
// No backpressure; en is the only throttle.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = H_TOTAL
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  assign wrap = (count == CNT_W'(TOTAL - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_driver.sv
// VGA raster generator: pixel-enable divider, h/v counters, address publish, colour/sync out.
// Address registered on PIX_EN; colour and syncs reach the pins exactly one pixel later.
// No backpressure: producer colour is sampled blindly on the next PIX_EN.
module vga_sync_driver
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VIS     = H_VISIBLE,
  parameter int H_FP      = H_FRONT,
  parameter int H_SW      = H_SYNC,
  parameter int H_BP      = H_BACK,
  parameter int V_VIS     = V_VISIBLE,
  parameter int V_FP      = V_FRONT,
  parameter int V_SW      = V_SYNC,
  parameter int V_BP      = V_BACK,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  vga_sync_driver_if.master vga
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] H_SYN_LO = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SYN_HI = CNT_W'(H_VIS + H_FP + H_SW);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] V_SYN_LO = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SYN_HI = CNT_W'(V_VIS + V_FP + V_SW);
  localparam logic [CNT_W-1:0] V_LAST_VIS = CNT_W'(V_VIS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap_unused;

  logic             visible;
  logic             hs_act;
  logic             vs_act;

  logic [ADDRH_W-1:0]  addrh_q;
  logic [ADDRV_W-1:0]  addrv_q;
  logic                vis_d;
  logic                hs_d;
  logic                vs_d;
  logic [COLOUR_W-1:0] colour_q;
  logic                hs_q;
  logic                vs_q;
  logic                refresh_q;

  // Registered pulse so the first PIX_EN lands CLK_DIV cycles after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      pix_en  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      pix_en  <= 1'b0;
    end
  end

  vga_axis_counter #(.TOTAL(H_TOT)) u_h_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (pix_en),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOT)) u_v_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (pix_en & h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap_unused)
  );

  assign visible = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hs_act  = in_window(h_cnt, H_SYN_LO, H_SYN_HI);
  assign vs_act  = in_window(v_cnt, V_SYN_LO, V_SYN_HI);

  // Stage 1 publishes the address; stage 2 pairs it with the producer's colour.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addrh_q   <= '0;
      addrv_q   <= '0;
      vis_d     <= 1'b0;
      hs_d      <= ~SYNC_POL;
      vs_d      <= ~SYNC_POL;
      colour_q  <= BLACK;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      refresh_q <= 1'b0;
    end else begin
      refresh_q <= pix_en && h_wrap && (v_cnt == V_LAST_VIS);
      if (pix_en) begin
        addrh_q  <= visible ? h_cnt : '0;
        addrv_q  <= visible ? v_cnt[ADDRV_W-1:0] : '0;
        vis_d    <= visible;
        hs_d     <= hs_act ? SYNC_POL : ~SYNC_POL;
        vs_d     <= vs_act ? SYNC_POL : ~SYNC_POL;
        colour_q <= vis_d ? vga.COLOUR_IN : BLACK;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
      end
    end
  end

  assign vga.ADDRH      = addrh_q;
  assign vga.ADDRV      = addrv_q;
  assign vga.PIX_EN     = pix_en;
  assign vga.REFRESH    = refresh_q;
  assign vga.COLOUR_OUT = colour_q;
  assign vga.HS         = hs_q;
  assign vga.VS         = vs_q;

endmodule

// File: tb/tb_vga_sync_driver.sv
// Bench for vga_sync_driver on a shrunk raster; reference model works from absolute
// cycle count since reset release using plain raster arithmetic.
module tb_vga_sync_driver;

  localparam int D   = 2;
  localparam int HV  = 24;
  localparam int HF  = 4;
  localparam int HSY = 6;
  localparam int HB  = 3;
  localparam int VV  = 10;
  localparam int VF  = 2;
  localparam int VSY = 2;
  localparam int VB  = 3;
  localparam int HT  = HV + HF + HSY + HB;
  localparam int VT  = VV + VF + VSY + VB;
  localparam int FRAME = D * HT * VT;

  typedef struct packed {
    logic [9:0] ah;
    logic [8:0] av;
    logic       pe;
    logic       rf;
    logic [7:0] co;
    logic       hs;
    logic       vs;
  } obs_t;

  logic       CLK;
  logic       RST_N;
  logic [7:0] salt;

  int vecs;
  int errs;
  int n;
  int last_hs_fall, last_vs_fall, last_rf_rise;
  logic prev_hs, prev_vs, prev_rf;

  vga_sync_driver_if vga ();

  assign vga.COLOUR_IN = vga.ADDRH[7:0] ^ salt;

  vga_sync_driver #(
    .CLK_DIV (D),
    .H_VIS (HV), .H_FP (HF), .H_SW (HSY), .H_BP (HB),
    .V_VIS (VV), .V_FP (VF), .V_SW (VSY), .V_BP (VB),
    .SYNC_POL (1'b0)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .vga   (vga)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected outputs after n clock edges since reset release.
  // Pixel k (k = 0,1,..) is addressed at the k+1'th PIX_EN and shown at the pins one pixel later.
  function automatic obs_t model(input int cyc, input logic [7:0] s);
    obs_t e;
    int m, q, h, v, p, hp, vp;
    e = '{ah: 10'd0, av: 9'd0, pe: 1'b0, rf: 1'b0, co: 8'd0, hs: 1'b1, vs: 1'b1};
    if (cyc < 1) return e;
    m = (cyc - 1) / D;
    e.pe = (cyc % D == 0);
    if (m >= 1) begin
      q = m - 1;
      h = q % HT;
      v = (q / HT) % VT;
      if (h < HV && v < VV) begin
        e.ah = 10'(h);
        e.av = 9'(v);
      end
      e.rf = ((cyc - 1) % D == 0) && (h == HT - 1) && (v == VV - 1);
    end
    if (m >= 2) begin
      p  = m - 2;
      hp = p % HT;
      vp = (p / HT) % VT;
      e.co = (hp < HV && vp < VV) ? (8'(hp) ^ s) : 8'd0;
      e.hs = !(hp >= HV + HF && hp < HV + HF + HSY);
      e.vs = !(vp >= VV + VF && vp < VV + VF + VSY);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic chk_all();
    obs_t e;
    e = model(n, salt);
    chk("ADDRH",      32'(vga.ADDRH),      32'(e.ah));
    chk("ADDRV",      32'(vga.ADDRV),      32'(e.av));
    chk("PIX_EN",     32'(vga.PIX_EN),     32'(e.pe));
    chk("REFRESH",    32'(vga.REFRESH),    32'(e.rf));
    chk("COLOUR_OUT", 32'(vga.COLOUR_OUT), 32'(e.co));
    chk("HS",         32'(vga.HS),         32'(e.hs));
    chk("VS",         32'(vga.VS),         32'(e.vs));
  endtask

  task automatic clear_track();
    last_hs_fall = -1;
    last_vs_fall = -1;
    last_rf_rise = -1;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    prev_rf = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    n++;
    chk_all();
    chk("addrv_max", 32'(vga.ADDRV < 9'(VV)), 32'd1);
    if (prev_hs && !vga.HS) begin
      if (last_hs_fall >= 0) chk("hs_period", 32'(n - last_hs_fall), 32'(D * HT));
      last_hs_fall = n;
    end
    if (!prev_hs && vga.HS && last_hs_fall >= 0)
      chk("hs_low", 32'(n - last_hs_fall), 32'(D * HSY));
    if (prev_vs && !vga.VS) last_vs_fall = n;
    if (!prev_vs && vga.VS && last_vs_fall >= 0)
      chk("vs_low", 32'(n - last_vs_fall), 32'(D * HT * VSY));
    if (!prev_rf && vga.REFRESH) begin
      if (last_rf_rise >= 0) chk("refresh_period", 32'(n - last_rf_rise), 32'(FRAME));
      last_rf_rise = n;
    end
    if (prev_rf && !vga.REFRESH)
      chk("refresh_width", 32'(n - last_rf_rise), 32'd1);
    prev_hs = vga.HS;
    prev_vs = vga.VS;
    prev_rf = vga.REFRESH;
  endtask

  // Asynchronous assert away from the edge, check at once, hold, then release mid-cycle.
  task automatic do_reset(input int hold);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    n = 0;
    chk_all();
    salt = 8'($urandom);
    repeat (hold) @(posedge CLK);
    #3;
    chk_all();
    RST_N = 1'b1;
    n = 0;
    clear_track();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic run_until(input string tag, input logic [9:0] h, input logic [8:0] v);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (vga.ADDRH == h && vga.ADDRV == v) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    n    = 0;
    salt = 8'h00;
    clear_track();
    RST_N = 1'b0;
    #22;
    chk_all();
    chk("reset_hs", 32'(vga.HS), 32'd1);
    #1;
    RST_N = 1'b1;
    n = 0;

    step();
    chk("first_pix_en_c1", 32'(vga.PIX_EN), 32'd0);
    step();
    chk("first_pix_en_c2", 32'(vga.PIX_EN), 32'd1);

    run_until("wait_5_7", 10'd5, 9'd7);
    run(D);
    chk("pix_5_7_colour", 32'(vga.COLOUR_OUT), 32'h05);
    run(2 * FRAME);

    run_until("wait_mid", 10'd12, 9'd5);
    do_reset(int'($urandom_range(1, 5)));
    run(2 * FRAME + 7);

    for (int r = 0; r < 3; r++) begin
      do_reset(int'($urandom_range(1, 6)));
      run(int'($urandom_range(1, FRAME)));
    end
    do_reset(2);
    run(FRAME + FRAME / 3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
